// File: rtl/dcache_port_arbiter.sv
// Data-cache SRAM port arbiter: snoop controller (port 0) has fixed priority, core-side
// ports are served round-robin, and a granted port owns the SRAM while it holds its request.
module dcache_port_arbiter #(
   parameter int unsigned NR_PORTS    = 4,
   parameter int unsigned SET_ASSOC   = 8,
   parameter int unsigned INDEX_WIDTH = 12,
   parameter int unsigned TAG_WIDTH   = 44,
   parameter int unsigned LINE_WIDTH  = 128
) (
   input  logic                                             clk_i,
   input  logic                                             rst_ni,
   input  logic [NR_PORTS*SET_ASSOC-1:0]                    req_i,
   input  logic [NR_PORTS*INDEX_WIDTH-1:0]                  addr_i,
   input  logic [NR_PORTS*TAG_WIDTH-1:0]                    tag_i,
   input  logic [NR_PORTS-1:0]                              we_i,
   input  logic [NR_PORTS*(LINE_WIDTH+3)-1:0]               wdata_i,
   input  logic [NR_PORTS*(LINE_WIDTH/8+SET_ASSOC)-1:0]     be_i,
   output logic [NR_PORTS-1:0]                              gnt_o,
   output logic [NR_PORTS-1:0]                              rvalid_o,
   output logic [SET_ASSOC-1:0]                             sram_req_o,
   output logic [INDEX_WIDTH-1:0]                           sram_addr_o,
   output logic [TAG_WIDTH-1:0]                             sram_tag_o,
   output logic                                             sram_we_o,
   output logic [LINE_WIDTH+2:0]                            sram_wdata_o,
   output logic [LINE_WIDTH/8+SET_ASSOC-1:0]                sram_be_o,
   input  logic                                             sram_gnt_i,
   output logic                                             updating_cache_o,
   output logic [$clog2(NR_PORTS)-1:0]                      owner_o
);

   localparam int unsigned PW    = $clog2(NR_PORTS);
   localparam int unsigned WD    = LINE_WIDTH + 3;
   localparam int unsigned BW    = LINE_WIDTH/8 + SET_ASSOC;
   localparam int unsigned NCORE = NR_PORTS - 1;

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [PW-1:0]       rr_q, rr_d;
   logic [PW-1:0]       tag_sel_q, tag_sel_d;
   logic [NR_PORTS-1:0] rvalid_q, rvalid_d;

   logic [NR_PORTS-1:0] active;
   logic                owner_active;
   logic                sel_valid;
   logic [PW-1:0]       sel;
   logic                granted;

   // Core-side candidate 'off' positions after base, wrapping NR_PORTS-1 back to 1.
   function automatic logic [PW-1:0] rr_cand(input logic [PW-1:0] base, input int unsigned off);
      int unsigned c;
      c = 32'(base) + off;
      if (c > NCORE) c = c - NCORE;
      return PW'(c);
   endfunction

   always_comb begin
      active = '0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         active[k] = |req_i[k*SET_ASSOC +: SET_ASSOC];
      end
   end

   assign owner_active = active[owner_q];

   always_comb begin
      sel_valid = 1'b0;
      sel       = '0;
      if (state_q == LOCKED && owner_active) begin
         sel_valid = 1'b1;
         sel       = owner_q;
      end else if (active[0]) begin
         sel_valid = 1'b1;
      end else begin
         for (int unsigned i = 1; i < NR_PORTS; i++) begin
            if (!sel_valid && active[rr_cand(rr_q, i)]) begin
               sel_valid = 1'b1;
               sel       = rr_cand(rr_q, i);
            end
         end
      end
   end

   assign granted = sel_valid & sram_gnt_i;

   always_comb begin
      gnt_o        = '0;
      sram_req_o   = '0;
      sram_addr_o  = '0;
      sram_we_o    = 1'b0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         if (sel_valid && sel == PW'(k)) begin
            gnt_o[k]     = sram_gnt_i;
            sram_req_o   = req_i[k*SET_ASSOC +: SET_ASSOC];
            sram_addr_o  = addr_i[k*INDEX_WIDTH +: INDEX_WIDTH];
            sram_we_o    = we_i[k];
            sram_wdata_o = wdata_i[k*WD +: WD];
            sram_be_o    = be_i[k*BW +: BW];
         end
      end
   end

   // The SRAM consumes the tag one cycle after the request, so follow the previous grant.
   always_comb begin
      sram_tag_o = '0;
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
         if (tag_sel_q == PW'(k)) sram_tag_o = tag_i[k*TAG_WIDTH +: TAG_WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      tag_sel_d = tag_sel_q;
      rvalid_d  = '0;
      case (state_q)
         IDLE: begin
            if (granted) state_d = LOCKED;
         end
         LOCKED: begin
            // Release and re-grant happen in the same cycle when the owner drops.
            if (!owner_active && !granted) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (granted) begin
         owner_d       = sel;
         tag_sel_d     = sel;
         rvalid_d[sel] = ~sram_we_o;
         if (sel != '0) rr_d = sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         rr_q      <= '0;
         tag_sel_q <= '0;
         rvalid_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         tag_sel_q <= tag_sel_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign rvalid_o         = rvalid_q;
   assign owner_o          = owner_q;
   assign updating_cache_o = (state_q == LOCKED) && (owner_q != '0) && owner_active;

endmodule
